// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
   parameter int unsigned CNT_W = 32
);
   logic [6:0]       op;
   logic [2:0]       funct3;
   logic             funct7b5;
   logic             Zero;
   logic             MemRdy;
   logic             PCWrite;
   logic             AdrSrc;
   logic             MemWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [2:0]       ALUControl;
   logic [1:0]       ImmSrc;
   logic             IllegalOp;
   logic [CNT_W-1:0] InstrRet;

   modport master (
      input  op, funct3, funct7b5, Zero, MemRdy,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalOp, InstrRet
   );

   modport slave (
      output op, funct3, funct7b5, Zero, MemRdy,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalOp, InstrRet
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core, with memory-ready wait
// states and a retired-instruction counter.
module multicycle_controller #(
   parameter int unsigned CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_controller_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] instr_ret;

   logic       pcupdate, branch, adrsrc, memwrite, irwrite, regwrite;
   logic       illegal, retire;
   logic [1:0] resultsrc, alusrca, alusrcb, aluop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FETCH;
         instr_ret <= '0;
      end else begin
         state <= state_nx;
         if (retire) instr_ret <= instr_ret + 1'b1;
      end
   end

   always_comb begin
      state_nx  = FETCH;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      adrsrc    = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      aluop     = 2'b00;
      case (state)
         FETCH: begin
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            irwrite   = bus.MemRdy;
            pcupdate  = bus.MemRdy;
            state_nx  = bus.MemRdy ? DECODE : FETCH;
         end
         DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (bus.op)
               7'b0000011, 7'b0100011: state_nx = MEMADR;
               7'b0110011:             state_nx = EXECUTER;
               7'b0010011:             state_nx = EXECUTEI;
               7'b1101111:             state_nx = JAL;
               7'b1100011:             state_nx = BEQ;
               default: begin
                  state_nx = FETCH;
                  illegal  = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alusrca  = 2'b10;
            alusrcb  = 2'b01;
            state_nx = bus.op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrsrc   = 1'b1;
            state_nx = bus.MemRdy ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
            retire    = 1'b1;
         end
         MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            retire   = bus.MemRdy;
            state_nx = bus.MemRdy ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            alusrca  = 2'b10;
            aluop    = 2'b10;
            state_nx = ALUWB;
         end
         EXECUTEI: begin
            alusrca  = 2'b10;
            alusrcb  = 2'b01;
            aluop    = 2'b10;
            state_nx = ALUWB;
         end
         ALUWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
         end
         JAL: begin
            alusrca  = 2'b01;
            alusrcb  = 2'b10;
            pcupdate = 1'b1;
            state_nx = ALUWB;
         end
         BEQ: begin
            alusrca = 2'b10;
            aluop   = 2'b01;
            branch  = 1'b1;
            retire  = 1'b1;
         end
         default: state_nx = FETCH;
      endcase
   end

   // Subtract only for R-type with funct7b5 set; addi ignores instr[30].
   always_comb begin
      bus.ALUControl = 3'b000;
      case (aluop)
         2'b01: bus.ALUControl = 3'b001;
         2'b10: begin
            case (bus.funct3)
               3'b000:  bus.ALUControl = ({bus.op[5], bus.funct7b5} == 2'b11) ? 3'b001 : 3'b000;
               3'b010:  bus.ALUControl = 3'b101;
               3'b110:  bus.ALUControl = 3'b011;
               3'b111:  bus.ALUControl = 3'b010;
               default: bus.ALUControl = 3'b000;
            endcase
         end
         default: bus.ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      case (bus.op)
         7'b0100011: bus.ImmSrc = 2'b01;
         7'b1100011: bus.ImmSrc = 2'b10;
         7'b1101111: bus.ImmSrc = 2'b11;
         default:    bus.ImmSrc = 2'b00;
      endcase
   end

   assign bus.PCWrite   = ~reset & (pcupdate | (branch & bus.Zero));
   assign bus.IRWrite   = ~reset & irwrite;
   assign bus.MemWrite  = ~reset & memwrite;
   assign bus.RegWrite  = ~reset & regwrite;
   assign bus.IllegalOp = ~reset & illegal;
   assign bus.AdrSrc    = adrsrc;
   assign bus.ResultSrc = resultsrc;
   assign bus.ALUSrcA   = alusrca;
   assign bus.ALUSrcB   = alusrcb;
   assign bus.InstrRet  = instr_ret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors per state.
module tb_multicycle_controller;
   localparam int unsigned CNT_W = 32;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   multicycle_controller_if #(.CNT_W(CNT_W)) bus ();
   multicycle_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, IllegalOp}
   logic [14:0] vec;
   assign vec = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                 bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.IllegalOp};

   localparam logic [14:0] V_FETCH1   = {1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,1'b0};
   localparam logic [14:0] V_FETCH0   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,1'b0};
   localparam logic [14:0] V_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,1'b0};
   localparam logic [14:0] V_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,1'b1};
   localparam logic [14:0] V_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,1'b0};
   localparam logic [14:0] V_MEMREAD  = {1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0};
   localparam logic [14:0] V_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,3'b000,1'b0};
   localparam logic [14:0] V_MEMWRITE = {1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0};
   localparam logic [14:0] V_EXR_SUB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,1'b0};
   localparam logic [14:0] V_EXR_OR   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b011,1'b0};
   localparam logic [14:0] V_EXI_ADD  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,1'b0};
   localparam logic [14:0] V_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,1'b0};
   localparam logic [14:0] V_JAL      = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,3'b000,1'b0};
   localparam logic [14:0] V_BEQ_T    = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,1'b0};
   localparam logic [14:0] V_BEQ_N    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,1'b0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply MemRdy/Zero for the current state, check its outputs, then advance one clock.
   task automatic cyc(input string tag, input logic rdy, input logic z, input logic [14:0] exp);
      bus.MemRdy = rdy;
      bus.Zero   = z;
      #1;
      check(tag, {17'd0, vec}, {17'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      bus.op       = o;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
   endtask

   initial begin
      reset = 1'b1;
      set_instr(7'b0000011, 3'b010, 1'b0);
      bus.MemRdy = 1'b1;
      bus.Zero   = 1'b0;

      // Enables forced low throughout reset.
      @(posedge clk); #1;
      cyc("reset_gate", 1'b1, 1'b0, V_FETCH0);
      reset = 1'b0;
      check("reset_instret", bus.InstrRet, 32'd0);

      // lw, 5 cycles
      cyc("lw_fetch", 1'b1, 1'b0, V_FETCH1);
      check("lw_imm", {30'd0, bus.ImmSrc}, 32'd0);
      cyc("lw_decode", 1'b1, 1'b0, V_DECODE);
      cyc("lw_memadr", 1'b1, 1'b0, V_MEMADR);
      cyc("lw_memread", 1'b1, 1'b0, V_MEMREAD);
      cyc("lw_memwb", 1'b1, 1'b0, V_MEMWB);
      check("lw_instret", bus.InstrRet, 32'd1);

      // sw with fetch stall and 3 MemRdy-low cycles in MEMWRITE
      set_instr(7'b0100011, 3'b010, 1'b0);
      cyc("sw_fetch_wait", 1'b0, 1'b0, V_FETCH0);
      cyc("sw_fetch", 1'b1, 1'b0, V_FETCH1);
      check("sw_imm", {30'd0, bus.ImmSrc}, 32'd1);
      cyc("sw_decode", 1'b1, 1'b0, V_DECODE);
      cyc("sw_memadr", 1'b1, 1'b0, V_MEMADR);
      for (int i = 0; i < 3; i++) cyc("sw_memwrite_wait", 1'b0, 1'b0, V_MEMWRITE);
      check("sw_instret_wait", bus.InstrRet, 32'd1);
      cyc("sw_memwrite_done", 1'b1, 1'b0, V_MEMWRITE);
      check("sw_instret", bus.InstrRet, 32'd2);

      // R-type sub
      set_instr(7'b0110011, 3'b000, 1'b1);
      cyc("sub_fetch", 1'b1, 1'b0, V_FETCH1);
      cyc("sub_decode", 1'b1, 1'b0, V_DECODE);
      cyc("sub_exec", 1'b1, 1'b0, V_EXR_SUB);
      cyc("sub_aluwb", 1'b1, 1'b0, V_ALUWB);
      check("sub_instret", bus.InstrRet, 32'd3);

      // addi with instr[30]=1 still adds
      set_instr(7'b0010011, 3'b000, 1'b1);
      cyc("addi_fetch", 1'b1, 1'b0, V_FETCH1);
      cyc("addi_decode", 1'b1, 1'b0, V_DECODE);
      cyc("addi_exec", 1'b1, 1'b0, V_EXI_ADD);
      cyc("addi_aluwb", 1'b1, 1'b0, V_ALUWB);
      check("addi_instret", bus.InstrRet, 32'd4);

      // R-type or
      set_instr(7'b0110011, 3'b110, 1'b0);
      cyc("or_fetch", 1'b1, 1'b0, V_FETCH1);
      cyc("or_decode", 1'b1, 1'b0, V_DECODE);
      cyc("or_exec", 1'b1, 1'b0, V_EXR_OR);
      cyc("or_aluwb", 1'b1, 1'b0, V_ALUWB);
      check("or_instret", bus.InstrRet, 32'd5);

      // beq taken / not taken
      set_instr(7'b1100011, 3'b000, 1'b0);
      cyc("beqt_fetch", 1'b1, 1'b0, V_FETCH1);
      check("beq_imm", {30'd0, bus.ImmSrc}, 32'd2);
      cyc("beqt_decode", 1'b1, 1'b0, V_DECODE);
      cyc("beqt_beq", 1'b1, 1'b1, V_BEQ_T);
      check("beqt_instret", bus.InstrRet, 32'd6);
      cyc("beqn_fetch", 1'b1, 1'b0, V_FETCH1);
      cyc("beqn_decode", 1'b1, 1'b1, V_DECODE);
      cyc("beqn_beq", 1'b1, 1'b0, V_BEQ_N);
      check("beqn_instret", bus.InstrRet, 32'd7);

      // jal
      set_instr(7'b1101111, 3'b000, 1'b0);
      cyc("jal_fetch", 1'b1, 1'b0, V_FETCH1);
      check("jal_imm", {30'd0, bus.ImmSrc}, 32'd3);
      cyc("jal_decode", 1'b1, 1'b0, V_DECODE);
      cyc("jal_jal", 1'b1, 1'b0, V_JAL);
      cyc("jal_aluwb", 1'b1, 1'b0, V_ALUWB);
      check("jal_instret", bus.InstrRet, 32'd8);

      // illegal opcode
      set_instr(7'b1111111, 3'b000, 1'b0);
      cyc("ill_fetch", 1'b1, 1'b0, V_FETCH1);
      check("ill_imm", {30'd0, bus.ImmSrc}, 32'd0);
      cyc("ill_decode", 1'b1, 1'b0, V_DEC_ILL);
      cyc("ill_back_fetch", 1'b0, 1'b0, V_FETCH0);
      check("ill_instret", bus.InstrRet, 32'd8);

      // reset while waiting in MEMREAD
      set_instr(7'b0000011, 3'b010, 1'b0);
      cyc("rst_fetch", 1'b1, 1'b0, V_FETCH1);
      cyc("rst_decode", 1'b1, 1'b0, V_DECODE);
      cyc("rst_memadr", 1'b1, 1'b0, V_MEMADR);
      cyc("rst_memread", 1'b0, 1'b0, V_MEMREAD);
      reset = 1'b1;
      cyc("rst_memread_rst", 1'b1, 1'b0, V_MEMREAD);
      reset = 1'b0;
      check("rst_instret", bus.InstrRet, 32'd0);
      cyc("rst_fetch_after", 1'b1, 1'b0, V_FETCH1);
      cyc("rst_decode_after", 1'b1, 1'b0, V_DECODE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle variant of the RV32I core: a Moore FSM that sequences a shared-memory datapath (one ALU, one memory port, instruction/data registers) through fetch, decode, execute, memory and writeback steps.
- Instruction subset: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/slti/ori/andi), beq, jal.
- Adds a memory-ready wait handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- MemRdy  in  1  memory completes access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  out  2  00=rs2, 01=immext, 10=constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- IllegalOp  out  1  one-cycle pulse in DECODE on an unsupported opcode
- InstrRet  out  CNT_W  count of completed instructions

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - Reset state is FETCH; InstrRet resets to 0.
  - While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are forced to 0.
  - Reset mid-instruction abandons the instruction with no writes.
- Outputs are a combinational decode of the state register only. Exceptions:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ImmSrc is decoded from op alone: lw/I-ALU→00, sw→01, beq→10, jal→11, other→00.
- ALUOp is internal and maps to ALUControl:
  - 00 → add.
  - 01 → sub.
  - 10 → funct3 decode: 000 → sub if {op[5],funct7b5}=11, else add; 010 slt; 110 or; 111 and; other → add.
- Unlisted signals default to 0/00 in every state.
- States, outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=MemRdy. Go to DECODE if MemRdy, else stay (PC and IR are not written while waiting).
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch/jump target into ALUOut). Next state by op:
    - 0000011/0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - else → FETCH with IllegalOp=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Stay until MemRdy, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until MemRdy, then FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB (rd ← OldPC+4).
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.
- Nominal cycle counts with MemRdy held at 1: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Each MemRdy=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly one cycle.
- InstrRet increments by 1 on the clock edge that leaves MEMWB, MEMWRITE (with MemRdy), ALUWB or BEQ. It wraps modulo 2^CNT_W and does not increment for illegal ops.
- Unreachable state encodings → FETCH next cycle with all enables 0.

Test Plan:
- Reset held 2 cycles then released, MemRdy=1 → state FETCH, IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, InstrRet=0.
- lw (op=0000011), MemRdy=1 → sequence FETCH/DECODE/MEMADR/MEMREAD/MEMWB over 5 cycles; RegWrite=1 only in cycle 5 with ResultSrc=01; InstrRet=1.
- sw with MemRdy low 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, RegWrite never 1, FETCH after MemRdy.
- R-type sub (funct3=000, funct7b5=1) → ALUControl=001 in EXECUTER. addi with funct7b5=1 → ALUControl=000. funct3=110 → 011.
- beq with Zero=1 → PCWrite=1 in BEQ. beq with Zero=0 → PCWrite=0. Both take 3 cycles and increment InstrRet.
- jal → PCWrite=1 in JAL, RegWrite=1 in ALUWB, ImmSrc=11. op=1111111 → IllegalOp pulse in DECODE, back to FETCH, InstrRet unchanged. Reset asserted in MEMREAD → FETCH next cycle, no RegWrite.
